// File: rtl/ms_flash_loader.sv
// Boot loader that copies a length-prefixed flash image into CPU ROM on a DBIO LOAD and reports status.
// Latency: ROM write 1 cycle after each flash ack; backpressure: one outstanding read, AFlRdReq held until ack.
module ms_flash_loader #(
    parameter logic [11:0] CBaseAddr   = 12'h100,
    parameter logic [23:0] CFlBase     = 24'h000000,
    parameter int          CRomAddrLen = 12,
    parameter int          CTimeout    = 1023
) (
    input  logic                   AClkH,
    input  logic                   AResetH,
    input  logic                   AClkHEn,
    input  logic [11:0]            ADbioAddr,
    input  logic [63:0]            ADbioMosi,
    input  logic [3:0]             ADbioMosiIdx,
    output logic                   ALdrActive,
    output logic [23:0]            AFlAddr,
    output logic                   AFlRdReq,
    input  logic                   AFlRdAck,
    input  logic [31:0]            AFlRdData,
    output logic [CRomAddrLen-1:0] ARomAddr,
    output logic [31:0]            ARomWrData,
    output logic                   ARomWrEn,
    output logic [7:0]             AStatus
);

    localparam logic [2:0] SIdle   = 3'd0;
    localparam logic [2:0] SHdrReq = 3'd1;
    localparam logic [2:0] SDatReq = 3'd2;
    localparam logic [2:0] SDrain  = 3'd3;
    localparam logic [2:0] SErr    = 3'd4;

    localparam int                     CWaitW    = $clog2(CTimeout + 1);
    localparam logic [CWaitW-1:0]      CWaitLast = CWaitW'(CTimeout - 1);
    localparam logic [CRomAddrLen:0]   CRomWords = {1'b1, {CRomAddrLen{1'b0}}};

    logic [2:0]             state;
    logic [CRomAddrLen:0]   wordCnt;
    logic [CRomAddrLen-1:0] romPtr;
    logic [CWaitW-1:0]      waitCnt;
    logic                   cmdVld;
    logic                   cmdLoad;
    logic                   cmdAbort;
    logic                   ackVld;
    logic                   timedOut;
    logic [15:0]            hdrLen;
    logic                   hdrBadMagic;
    logic                   hdrOversize;
    logic [2:0]             errCode;
    logic                   unusedMosi;

    assign cmdVld      = (ADbioMosiIdx != 4'd0) && (ADbioAddr == CBaseAddr);
    assign cmdLoad     = cmdVld && (ADbioMosi[7:0] == 8'h01);
    assign cmdAbort    = cmdVld && (ADbioMosi[7:0] == 8'h02);
    assign ackVld      = AFlRdReq && AFlRdAck;
    assign timedOut    = AFlRdReq && !AFlRdAck && (waitCnt == CWaitLast);
    assign hdrLen      = AFlRdData[15:0];
    assign hdrBadMagic = AFlRdData[31:16] != 16'hA55A;
    assign hdrOversize = 32'(hdrLen) > 32'(CRomWords);
    assign ALdrActive  = state != SIdle;
    assign unusedMosi  = ^ADbioMosi[63:8];

    // Abort outranks everything, so an ack landing with it is simply dropped.
    always_comb begin
        errCode = 3'd0;
        if ((state == SHdrReq || state == SDatReq || state == SDrain) && cmdAbort)
            errCode = 3'd4;
        else if (state == SHdrReq && ackVld && hdrBadMagic)
            errCode = 3'd1;
        else if (state == SHdrReq && ackVld && hdrOversize)
            errCode = 3'd2;
        else if ((state == SHdrReq || state == SDatReq) && timedOut)
            errCode = 3'd3;
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state      <= SIdle;
            AFlAddr    <= '0;
            AFlRdReq   <= 1'b0;
            ARomAddr   <= '0;
            ARomWrData <= '0;
            ARomWrEn   <= 1'b0;
            AStatus    <= '0;
            wordCnt    <= '0;
            romPtr     <= '0;
            waitCnt    <= '0;
        end else if (AClkHEn) begin
            ARomWrEn <= 1'b0;
            waitCnt  <= (AFlRdReq && !AFlRdAck) ? waitCnt + CWaitW'(1) : '0;
            if (errCode != 3'd0) begin
                AStatus[2:0] <= errCode;
                AFlRdReq     <= 1'b0;
                state        <= SErr;
            end else begin
                case (state)
                    SIdle: begin
                        if (cmdLoad) begin
                            AStatus  <= '0;
                            AFlAddr  <= CFlBase;
                            AFlRdReq <= 1'b1;
                            state    <= SHdrReq;
                        end
                    end
                    SHdrReq: begin
                        if (ackVld) begin
                            AFlRdReq <= 1'b0;
                            if (hdrLen == 16'd0) begin
                                AStatus[7] <= 1'b1;
                                state      <= SIdle;
                            end else begin
                                wordCnt <= (CRomAddrLen + 1)'(hdrLen);
                                AFlAddr <= AFlAddr + 24'd1;
                                romPtr  <= '0;
                                state   <= SDatReq;
                            end
                        end
                    end
                    SDatReq: begin
                        if (ackVld) begin
                            ARomWrData <= AFlRdData;
                            ARomAddr   <= romPtr;
                            ARomWrEn   <= 1'b1;
                            romPtr     <= romPtr + CRomAddrLen'(1);
                            AFlAddr    <= AFlAddr + 24'd1;
                            wordCnt    <= wordCnt - (CRomAddrLen + 1)'(1);
                            AFlRdReq   <= 1'b0;
                            if (wordCnt == (CRomAddrLen + 1)'(1))
                                state <= SDrain;
                        end else if (!AFlRdReq) begin
                            AFlRdReq <= 1'b1;
                        end
                    end
                    SDrain: begin
                        AStatus[7] <= 1'b1;
                        state      <= SIdle;
                    end
                    SErr: begin
                        AStatus[6] <= 1'b1;
                        state      <= SIdle;
                    end
                    default: state <= SIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ms_flash_loader.sv
// Directed bench for ms_flash_loader with a one-cycle-latency flash responder and a ROM write log.
module tb_ms_flash_loader;

    logic        AClkH = 1'b0;
    logic        AResetH;
    logic        AClkHEn;
    logic [11:0] ADbioAddr;
    logic [63:0] ADbioMosi;
    logic [3:0]  ADbioMosiIdx;
    logic        ALdrActive;
    logic [23:0] AFlAddr;
    logic        AFlRdReq;
    logic        AFlRdAck = 1'b0;
    logic [31:0] AFlRdData = 32'h0;
    logic [11:0] ARomAddr;
    logic [31:0] ARomWrData;
    logic        ARomWrEn;
    logic [7:0]  AStatus;

    int checks = 0;
    int failures = 0;

    logic [31:0] flashMem [0:15];
    int          ackCount = 0;
    int          ackLimit = 0;
    bit          reqHeld = 1'b0;
    int          wrCount = 0;
    logic [11:0] wrAddr [0:255];
    logic [31:0] wrData [0:255];

    ms_flash_loader #(.CTimeout(16)) dut (
        .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
        .ADbioAddr(ADbioAddr), .ADbioMosi(ADbioMosi), .ADbioMosiIdx(ADbioMosiIdx),
        .ALdrActive(ALdrActive), .AFlAddr(AFlAddr), .AFlRdReq(AFlRdReq),
        .AFlRdAck(AFlRdAck), .AFlRdData(AFlRdData), .ARomAddr(ARomAddr),
        .ARomWrData(ARomWrData), .ARomWrEn(ARomWrEn), .AStatus(AStatus)
    );

    always #5 AClkH = ~AClkH;

    // Flash acks one cycle after a request rises; ROM log records strobes the next edge will commit.
    always @(negedge AClkH) begin
        if (AClkHEn && ARomWrEn) begin
            wrAddr[wrCount] = ARomAddr;
            wrData[wrCount] = ARomWrData;
            wrCount++;
        end
        if (AFlRdReq && reqHeld && ackCount < ackLimit) begin
            AFlRdAck  = 1'b1;
            AFlRdData = flashMem[AFlAddr[3:0]];
        end else begin
            AFlRdAck = 1'b0;
        end
        if (AClkHEn) begin
            if (AFlRdAck) ackCount++;
            reqHeld = AFlRdReq && !AFlRdAck && !AResetH;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge AClkH);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendCmd(input logic [7:0] code);
        ADbioAddr    = 12'h100;
        ADbioMosi    = {56'h0, code};
        ADbioMosiIdx = 4'd1;
        step(1);
        ADbioMosiIdx = 4'd0;
        ADbioMosi    = 64'h0;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (ALdrActive && n < 300) begin
            n++;
            step(1);
        end
    endtask

    task automatic setImage(input logic [31:0] hdr);
        for (int i = 0; i < 16; i++) flashMem[i] = 32'h0;
        flashMem[0] = hdr;
        flashMem[1] = 32'hDEAD0000;
        flashMem[2] = 32'hBEEF0001;
        flashMem[3] = 32'hCAFE0002;
    endtask

    task automatic chkWrites(input string tag, input int base, input int n);
        chk({tag, "_wrcnt"}, 64'(wrCount - base), 64'(n));
        for (int i = 0; i < n && i < wrCount - base; i++) begin
            chk({tag, "_wraddr"}, 64'(wrAddr[base + i]), 64'(i));
            chk({tag, "_wrdata"}, 64'(wrData[base + i]), 64'(flashMem[1 + i]));
        end
    endtask

    task automatic chkResetOuts(input string tag);
        chk({tag, "_ctl"}, 64'({ALdrActive, AFlRdReq, ARomWrEn, AStatus}), 64'(0));
        chk({tag, "_addr"}, 64'({AFlAddr, ARomAddr, ARomWrData}), 64'(0));
    endtask

    initial begin
        int n;
        int base;
        AResetH      = 1'b1;
        AClkHEn      = 1'b1;
        ADbioAddr    = 12'h0;
        ADbioMosi    = 64'h0;
        ADbioMosiIdx = 4'd0;
        setImage(32'hA55A0003);
        step(3);
        chkResetOuts("rst");
        AResetH = 1'b0;
        step(2);

        // Normal three-word load
        ackLimit = ackCount + 1000;
        base = wrCount;
        sendCmd(8'h01);
        chk("norm_rise", 64'({ALdrActive, AFlRdReq, AFlAddr}), 64'({2'b11, 24'h0}));
        waitIdle(n);
        chk("norm_len", 64'(n), 64'(12));
        chk("norm_stat", 64'(AStatus), 64'h80);
        chk("norm_req", 64'(AFlRdReq), 64'(0));
        chkWrites("norm", base, 3);
        chk("norm_hold", 64'({ARomAddr, ARomWrData}), 64'({12'd2, 32'hCAFE0002}));

        // ABORT while idle does nothing
        sendCmd(8'h02);
        chk("idle_abort", 64'({ALdrActive, AStatus}), 64'({1'b0, 8'h80}));

        // Zero-length image
        setImage(32'hA55A0000);
        base = wrCount;
        sendCmd(8'h01);
        chk("zero_clr", 64'(AStatus), 64'h00);
        waitIdle(n);
        chk("zero_len", 64'(n), 64'(2));
        chk("zero_stat", 64'(AStatus), 64'h80);
        chkWrites("zero", base, 0);

        // Bad magic and oversize headers
        setImage(32'h12340004);
        base = wrCount;
        sendCmd(8'h01);
        waitIdle(n);
        chk("magic_len", 64'(n), 64'(3));
        chk("magic_stat", 64'(AStatus), 64'h41);
        chkWrites("magic", base, 0);

        setImage(32'hA55A1001);
        sendCmd(8'h01);
        waitIdle(n);
        chk("over_stat", 64'(AStatus), 64'h42);
        chkWrites("over", base, 0);

        // Exactly 2^12 words passes the header check
        setImage(32'hA55A1000);
        sendCmd(8'h01);
        step(2);
        chk("max_ok", 64'({ALdrActive, AFlAddr, AStatus}), 64'({1'b1, 24'h1, 8'h00}));
        sendCmd(8'h02);
        waitIdle(n);
        chk("max_abort", 64'(AStatus), 64'h44);
        chkWrites("max", base, 0);

        // Ack timeout on the second data word
        setImage(32'hA55A0003);
        ackLimit = ackCount + 2;
        base = wrCount;
        sendCmd(8'h01);
        waitIdle(n);
        chk("to_len", 64'(n >= 23 && n <= 24), 64'(1));
        chk("to_stat", 64'({ALdrActive, AStatus}), 64'({1'b0, 8'h43}));
        chkWrites("to", base, 1);

        // Abort with a ROM write pending, then restart
        ackLimit = ackCount + 1000;
        base = wrCount;
        sendCmd(8'h01);
        step(5);
        chk("ab_pend", 64'(ARomWrEn), 64'(1));
        sendCmd(8'h02);
        waitIdle(n);
        chk("ab_stat", 64'(AStatus), 64'h44);
        chkWrites("ab", base, 1);

        base = wrCount;
        sendCmd(8'h01);
        chk("re_start", 64'({AStatus, AFlRdReq, AFlAddr}), 64'({8'h00, 1'b1, 24'h0}));
        step(1);
        sendCmd(8'h01);
        waitIdle(n);
        chk("re_len", 64'(n), 64'(10));
        chk("re_stat", 64'(AStatus), 64'h80);
        chkWrites("re", base, 3);

        // Synchronous reset mid-load
        base = wrCount;
        sendCmd(8'h01);
        step(6);
        chk("mr_pre", 64'({AFlRdReq, AFlAddr}), 64'({1'b1, 24'h2}));
        AResetH = 1'b1;
        step(1);
        chkResetOuts("mr");
        AResetH = 1'b0;
        step(20);
        chk("mr_idle", 64'(ALdrActive), 64'(0));
        chkWrites("mr", base, 1);

        // Clock-enable freeze mid-load
        base = wrCount;
        sendCmd(8'h01);
        step(2);
        AClkHEn = 1'b0;
        step(2);
        chk("gate_frz", 64'({ALdrActive, AFlRdReq, AFlAddr}), 64'({2'b10, 24'h1}));
        step(3);
        AClkHEn = 1'b1;
        waitIdle(n);
        chk("gate_len", 64'(n), 64'(10));
        chk("gate_stat", 64'(AStatus), 64'h80);
        chkWrites("gate", base, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ms_flash_loader.md
# ms_flash_loader

Boot-image loader that executes the "load from flash" command issued on the DBIO bus by the startup sequencer. It copies a length-prefixed image from the flash read port into the CPU instruction ROM, one 32-bit word at a time. While it works it holds `ALdrActive` high, and the sequencer waits on that signal before starting the CPU. The block sits directly downstream of the startup sequencer's DBIO outputs and upstream of its `ALdrActive` input.

## Interface
Parameters:
- `CBaseAddr`, 12'h100, DBIO address the loader decodes.
- `CFlBase`, 24'h000000, flash word address of the image header.
- `CRomAddrLen`, 12, ROM word-address width; capacity is 2^CRomAddrLen words.
- `CTimeout`, 1023, maximum number of cycles to wait for `AFlRdAck`.

Ports:
- `AClkH` in 1: clock.
- `AResetH` in 1: synchronous reset, active-high.
- `AClkHEn` in 1: clock enable; all state holds while low.
- `ADbioAddr` in 12: DBIO address.
- `ADbioMosi` in 64: DBIO write data; command code in [7:0].
- `ADbioMosiIdx` in 4: number of valid MOSI bytes; 0 means no transaction.
- `ALdrActive` out 1: load in progress.
- `AFlAddr` out 24: flash word address.
- `AFlRdReq` out 1: flash read request (level).
- `AFlRdAck` in 1: read acknowledge; `AFlRdData` is valid in the same cycle.
- `AFlRdData` in 32: flash read data.
- `ARomAddr` out CRomAddrLen: ROM write address.
- `ARomWrData` out 32: ROM write data.
- `ARomWrEn` out 1: ROM write strobe, one cycle per word.
- `AStatus` out 8: {done, err, 3'b0, errcode[2:0]}; sticky until the next accepted load command or reset.

## Operation
- **Command decode.** A command is accepted in a cycle where `AClkHEn`=1, `ADbioMosiIdx`!=0 and `ADbioAddr`==`CBaseAddr`.
  - Code 8'h01 = LOAD. It is ignored while busy.
  - Code 8'h02 = ABORT. It is ignored while Idle.
  - Any other code is ignored.
- **States:** Idle, HdrReq, DatReq, Drain, Err.
  - **Idle.** LOAD clears `AStatus`, loads `AFlAddr`=`CFlBase`, and moves to HdrReq.
  - **HdrReq.** `AFlRdReq`=1. On ack, check the header: [31:16] must be 16'hA55A and [15:0] is the word count N.
    - Bad magic: errcode 1, go to Err.
    - N > 2^CRomAddrLen: errcode 2, go to Err.
    - N==0: set done, go to Idle.
    - Otherwise: count:=N, `AFlAddr`+=1, ROM pointer:=0, go to DatReq.
  - **DatReq.** `AFlRdReq`=1. On each ack:
    - capture the data;
    - in the next cycle pulse `ARomWrEn` with `ARomAddr`=pointer;
    - increment the pointer and `AFlAddr`, decrement count.
    - When count reaches 0, go to Drain.
  - **Drain.** One cycle that lets the last ROM write commit. Then set done and go to Idle.
  - **Err.** Set err and go to Idle in one cycle.
- **Flash handshake.** At most one read is outstanding. `AFlRdReq` stays high until the ack cycle and drops for exactly one cycle after each ack, so back-to-back reads are at most one word per 2 cycles. `AFlAddr` is stable while `AFlRdReq`=1.
- **Timeout.** The wait counter resets on every request edge. If `CTimeout` cycles pass without an ack in HdrReq or DatReq: errcode 3, go to Err.
- **Abort.** ABORT in any busy state sets errcode 4 and goes to Err. A pending ROM write still completes. A flash ack arriving in the same cycle is discarded.
- **Arithmetic.** `AFlAddr` wraps modulo 2^24. The ROM pointer never wraps, because N is bounded by the header check.
- **Outputs when not writing.** `ARomWrData` and `ARomAddr` hold their last value when `ARomWrEn`=0.

## Timing
- **Reset values:** `ALdrActive`=0, `AFlRdReq`=0, `AFlAddr`=0, `ARomWrEn`=0, `ARomAddr`=0, `ARomWrData`=0, `AStatus`=0, state Idle. Reset mid-load abandons the load immediately; no further ROM writes occur.
- **`ALdrActive` rise.** Registered: command accepted in cycle C gives `ALdrActive`=1 and `AFlRdReq`=1 in cycle C+1. The sequencer samples it from C+1, so it never sees a false idle.
- **`ALdrActive` fall.** It is 0 in the cycle after the Drain, Err, or N==0 header cycle. The done/err bits are valid in that same cycle.
- **Write latency.** An ack in cycle A gives `ARomWrEn`=1 in A+1.
- **Simultaneous LOAD and ack.** LOAD while busy coinciding with an ack is ignored; the ack is processed normally.

## Test plan
- **Normal load.** Header 32'hA55A0003 and data D0..D2, ack 1 cycle after each request -> ROM writes to addr 0,1,2 with D0..D2. `ALdrActive` high from C+1 and low 1 cycle after Drain. `AStatus`=8'h80.
- **Zero-length image.** Header 32'hA55A0000 -> no ROM writes, `ALdrActive` high for exactly 2 cycles, `AStatus`=8'h80.
- **Bad header.** Header 32'h12340004 -> no writes, `AStatus`=8'h41. Oversize header 32'hA55A1001 with `CRomAddrLen`=12 -> `AStatus`=8'h42.
- **Ack timeout.** No ack after the second data request -> exactly 1 ROM write, then `AStatus`=8'h43 after `CTimeout` cycles, `ALdrActive`=0.
- **Abort.** Write code 8'h02 at 12'h100 mid-load -> `AStatus`=8'h44 and no writes after the pending one. A following LOAD restarts from `CFlBase` with `AStatus` cleared.
- **Reset and gating.** `AResetH` pulse mid-load -> all outputs at reset values next cycle. `AClkHEn`=0 for 5 cycles mid-load -> state, addresses and counters frozen, then the load completes correctly.
